// File: rtl/e_mdu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : e_mdu_ctrl_pkg
// Purpose  : Shared encodings for the E-stage multiply/divide unit: 4-bit MDU
//            op codes, sequencer state type and small op-decode helpers.
// Revision : 1.0 - initial release
// ============================================================================
package e_mdu_ctrl_pkg;

    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MFHI  = 4'd5;
    localparam logic [3:0] MDU_MFLO  = 4'd6;
    localparam logic [3:0] MDU_MTHI  = 4'd7;
    localparam logic [3:0] MDU_MTLO  = 4'd8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_t;

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/e_mdu_ctrl_arith.sv
`default_nettype none
// ============================================================================
// Module   : e_mdu_ctrl_arith
// Purpose  : Stateless arithmetic core of the MDU. Maps a latched op and its
//            operands to a 64-bit {hi,lo} result plus a divide-by-zero flag.
// Ports    : i_op     - latched MDU op code
//            i_a/i_b  - latched rs/rt operands
//            o_result - {hi,lo}; 0 for non-arithmetic ops
//            o_div0   - divide op with a zero divisor (caller must not commit)
// Revision : 1.0 - initial release
// ============================================================================
module e_mdu_ctrl_arith
    import e_mdu_ctrl_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [63:0] o_result,
    output logic        o_div0
);

    logic signed [63:0] w_sa64;
    logic signed [63:0] w_sb64;
    logic        [63:0] w_sprod;
    logic        [63:0] w_uprod;
    logic        [31:0] w_b_safe;
    logic signed [31:0] w_sa32;
    logic signed [31:0] w_sb32;
    logic        [31:0] w_squo;
    logic        [31:0] w_srem;
    logic        [31:0] w_uquo;
    logic        [31:0] w_urem;
    logic               w_b_zero;
    logic               w_sdiv_ovf;

    // Sign-extend to 64 bits so the low 64 bits of the product are exact.
    assign w_sa64  = {{32{i_a[31]}}, i_a};
    assign w_sb64  = {{32{i_b[31]}}, i_b};
    assign w_sprod = w_sa64 * w_sb64;
    assign w_uprod = {32'd0, i_a} * {32'd0, i_b};

    // A zero divisor is replaced by 1 so the dividers never see x/0; the
    // result is discarded through o_div0 anyway.
    assign w_b_zero = (i_b == 32'd0);
    assign w_b_safe = w_b_zero ? 32'd1 : i_b;
    assign w_sa32   = i_a;
    assign w_sb32   = w_b_safe;
    assign w_squo   = w_sa32 / w_sb32;
    assign w_srem   = w_sa32 % w_sb32;
    assign w_uquo   = i_a / w_b_safe;
    assign w_urem   = i_a % w_b_safe;

    // INT_MIN / -1 overflows two's complement; pin its result explicitly.
    assign w_sdiv_ovf = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);

    always_comb begin
        o_result = 64'd0;
        o_div0   = 1'b0;
        case (i_op)
            MDU_MULT:  o_result = w_sprod;
            MDU_MULTU: o_result = w_uprod;
            MDU_DIV: begin
                if (w_b_zero)        o_div0   = 1'b1;
                else if (w_sdiv_ovf) o_result = {32'd0, 32'h8000_0000};
                else                 o_result = {w_srem, w_squo};
            end
            MDU_DIVU: begin
                if (w_b_zero) o_div0   = 1'b1;
                else          o_result = {w_urem, w_uquo};
            end
            default: o_result = 64'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/e_mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : e_mdu_ctrl
// Purpose  : E-stage multiply/divide sequencer. Latches one MULT/MULTU/DIV/DIVU
//            at a time, holds E_Busy for a fixed latency, commits to HI/LO,
//            and services MTHI/MTLO writes and MFHI/MFLO reads.
// Ports    : clk, reset_n (async active-low)
//            E_MDUOp  - MDU op code of the E-stage instruction
//            A, B     - forwarded rs/rt operands
//            Start    - E-stage instruction starts a multi-cycle op
//            Req      - flush this cycle; blocks new starts and HI/LO moves
//            E_Busy   - op in flight
//            HI, LO   - architectural HI/LO registers
//            E_MDUOut - HI for MFHI, LO for MFLO, else 0
// Revision : 1.0 - initial release
// ============================================================================
module e_mdu_ctrl
    import e_mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  E_MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Start,
    input  logic        Req,
    output logic        E_Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] E_MDUOut
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    mdu_state_t       r_state;
    logic [CNT_W-1:0] r_count;
    logic [3:0]       r_op;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic             r_busy;
    logic [63:0]      w_result;
    logic             w_div0;

    e_mdu_ctrl_arith u_arith (
        .i_op     (r_op),
        .i_a      (r_a),
        .i_b      (r_b),
        .o_result (w_result),
        .o_div0   (w_div0)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_op    <= MDU_NONE;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (Start && !Req) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_op    <= E_MDUOp;
                        r_a     <= A;
                        r_b     <= B;
                        r_count <= is_div_op(E_MDUOp) ? DIV_LOAD : MULT_LOAD;
                    end else if (!Req && (E_MDUOp == MDU_MTHI)) begin
                        r_hi <= A;
                    end else if (!Req && (E_MDUOp == MDU_MTLO)) begin
                        r_lo <= A;
                    end
                end
                ST_RUN: begin
                    // Req is deliberately ignored here: the op is past M and
                    // must complete.
                    if (r_count == '0) begin
                        if (!w_div0) begin
                            r_hi <= w_result[63:32];
                            r_lo <= w_result[31:0];
                        end
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign E_Busy   = r_busy;
    assign HI       = r_hi;
    assign LO       = r_lo;
    assign E_MDUOut = (E_MDUOp == MDU_MFHI) ? r_hi :
                      (E_MDUOp == MDU_MFLO) ? r_lo : 32'd0;

endmodule
`default_nettype wire
